// File: rtl/data_memory_master_pkg.sv
// Shared types and constants for the data-memory initiator: FSM state encoding,
// default strobe timing and the address helpers used when a request is accepted.
package data_memory_master_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        RESP   = 3'd4
    } state_t;

    localparam logic ERR_FLAG = 1'b1;

    localparam int DEFAULT_SETUP_CYCLES  = 1;
    localparam int DEFAULT_STROBE_CYCLES = 1;
    localparam int DEFAULT_HOLD_CYCLES   = 1;
    localparam int DEFAULT_ADDR_BITS     = 12;

    // Width of the shared phase counter; phases longer than 2**CNT_BITS are not supported.
    localparam int CNT_BITS = 16;

    function automatic logic [31:0] word_index(input logic [31:0] addr, input bit word_mode);
        return word_mode ? (addr >> 2) : addr;
    endfunction

    // A request is rejected when it is not word aligned or decodes outside the memory.
    function automatic logic addr_error(input logic [31:0] addr, input bit word_mode,
                                        input int addr_bits);
        logic [31:0] idx;
        idx = word_index(addr, word_mode);
        return (addr[1:0] != 2'b00) || ((idx >> addr_bits) != 32'd0);
    endfunction

endpackage

// File: rtl/data_memory_master_if.sv
// Request/response handshake plus asynchronous memory pins of the data-memory initiator.
interface data_memory_master_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        busy;

    logic [31:0] mem_addr;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, mem_dout,
        output req_ready, resp_valid, resp_rdata, resp_error, busy,
        output mem_addr, mem_ren, mem_wen, mem_din
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, mem_dout,
        input  req_ready, resp_valid, resp_rdata, resp_error, busy,
        input  mem_addr, mem_ren, mem_wen, mem_din
    );

endinterface

// File: rtl/data_memory_master_mem_wait_counter.sv
// Loadable down-counter timing the setup, strobe and hold phases; it stops at zero
// so a phase can never wrap around into a very long wait.
module mem_wait_counter
    import data_memory_master_pkg::*;
#(
    parameter int WIDTH = CNT_BITS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             enable,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= value;
        end else if (enable && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/data_memory_master.sv
// Initiator for an asynchronous data memory: one load or store at a time, sequenced
// as address/data setup, strobe, hold, then a single-cycle response.
module data_memory_master
    import data_memory_master_pkg::*;
#(
    parameter int SETUP_CYCLES  = DEFAULT_SETUP_CYCLES,
    parameter int STROBE_CYCLES = DEFAULT_STROBE_CYCLES,
    parameter int HOLD_CYCLES   = DEFAULT_HOLD_CYCLES,
    parameter int ADDR_BITS     = DEFAULT_ADDR_BITS,
    parameter bit WORD_INDEX    = 1'b1
) (
    input logic                  clock,
    input logic                  reset,
    data_memory_master_if.master bus
);

    if (SETUP_CYCLES < 1 || STROBE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_timing
        $error("data_memory_master: SETUP/STROBE/HOLD_CYCLES must all be >= 1");
    end

    localparam logic [CNT_BITS-1:0] SETUP_LOAD  = CNT_BITS'(SETUP_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] STROBE_LOAD = CNT_BITS'(STROBE_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] HOLD_LOAD   = CNT_BITS'(HOLD_CYCLES - 1);

    state_t state_q;
    state_t next_state;

    logic                write_q;
    logic [31:0]         rdata_q;

    logic                cnt_load;
    logic [CNT_BITS-1:0] cnt_value;
    logic                cnt_enable;
    logic                cnt_zero;

    logic                accept;
    logic                accept_error;
    logic                capture;
    logic                req_error;
    logic [31:0]         req_index;

    assign req_error = addr_error(bus.req_addr, WORD_INDEX, ADDR_BITS);
    assign req_index = word_index(bus.req_addr, WORD_INDEX);

    mem_wait_counter #(
        .WIDTH (CNT_BITS)
    ) u_wait (
        .clock  (clock),
        .reset  (reset),
        .load   (cnt_load),
        .value  (cnt_value),
        .enable (cnt_enable),
        .zero   (cnt_zero)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave
        // one unassigned and turn this block into a latch.
        next_state   = state_q;
        cnt_load     = 1'b0;
        cnt_value    = '0;
        cnt_enable   = 1'b0;
        accept       = 1'b0;
        accept_error = 1'b0;
        capture      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (req_error) begin
                        accept_error = 1'b1;
                        next_state   = RESP;
                    end else begin
                        cnt_load   = 1'b1;
                        cnt_value  = SETUP_LOAD;
                        next_state = SETUP;
                    end
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    cnt_load   = 1'b1;
                    cnt_value  = STROBE_LOAD;
                    next_state = STROBE;
                end else begin
                    cnt_enable = 1'b1;
                end
            end
            STROBE: begin
                if (cnt_zero) begin
                    // Read data is sampled while ren is still high, on the last strobe edge.
                    capture    = !write_q;
                    cnt_load   = 1'b1;
                    cnt_value  = HOLD_LOAD;
                    next_state = HOLD;
                end else begin
                    cnt_enable = 1'b1;
                end
            end
            HOLD: begin
                if (cnt_zero) begin
                    next_state = RESP;
                end else begin
                    cnt_enable = 1'b1;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // All outputs are registered against next_state so nothing from req_* reaches the
    // memory pins combinationally, and reset drops the strobes immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            write_q        <= 1'b0;
            rdata_q        <= '0;
            bus.req_ready  <= 1'b1;
            bus.busy       <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_error <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_ren    <= 1'b0;
            bus.mem_wen    <= 1'b0;
            bus.mem_din    <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples pre-edge values,
            // whatever order the statements are written in.
            state_q        <= next_state;
            bus.req_ready  <= (next_state == IDLE);
            bus.busy       <= (next_state != IDLE);
            bus.mem_ren    <= (next_state == STROBE) && !write_q;
            bus.mem_wen    <= (next_state == STROBE) && write_q;
            bus.resp_valid <= (next_state == RESP);

            if (accept) begin
                write_q <= bus.req_write;
                if (!req_error) begin
                    bus.mem_addr <= req_index;
                    bus.mem_din  <= bus.req_write ? bus.req_wdata : 32'd0;
                end
            end

            if (capture) begin
                rdata_q <= bus.mem_dout;
            end

            if (next_state == RESP) begin
                bus.resp_error <= accept_error ? ERR_FLAG : ~ERR_FLAG;
                bus.resp_rdata <= (accept_error || write_q) ? 32'd0 : rdata_q;
            end

            if (state_q == RESP) begin
                bus.mem_addr <= '0;
                bus.mem_din  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_master.sv
// Self-checking bench: a cycle-timeline model of the initiator is compared against two
// DUTs (default timing and 2/3/2 timing) every cycle, plus hand-computed directed checks.
module tb_data_memory_master;

    typedef struct packed {
        logic        req_ready;
        logic        busy;
        logic        resp_valid;
        logic        resp_error;
        logic [31:0] resp_rdata;
        logic        mem_ren;
        logic        mem_wen;
        logic [31:0] mem_addr;
        logic [31:0] mem_din;
    } outs_t;

    // Request in flight, seen as "we are in cycle k of a request that ends in cycle lat".
    typedef struct {
        bit        active;
        int        k;
        int        lat;
        bit        err;
        bit        write;
        bit [31:0] idx;
        bit [31:0] wdata;
        bit [31:0] rdata;
        bit        rerr;
    } model_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    int s_cyc [2] = '{1, 2};
    int t_cyc [2] = '{1, 3};
    int h_cyc [2] = '{1, 2};

    logic        req_valid_d [2];
    logic        req_write_d [2];
    logic [31:0] req_addr_d  [2];
    logic [31:0] req_wdata_d [2];

    bit [31:0] sram_a [4096];
    bit [31:0] sram_b [4096];
    bit [31:0] mmem   [2][4096];
    model_t    m      [2];
    outs_t     act    [2];
    bit [31:0] resp_q_a [$];

    data_memory_master_if bus_a ();
    data_memory_master_if bus_b ();

    data_memory_master dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a.master)
    );

    data_memory_master #(
        .SETUP_CYCLES  (2),
        .STROBE_CYCLES (3),
        .HOLD_CYCLES   (2)
    ) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b.master)
    );

    always #5 clock = ~clock;

    assign bus_a.req_valid = req_valid_d[0];
    assign bus_a.req_write = req_write_d[0];
    assign bus_a.req_addr  = req_addr_d[0];
    assign bus_a.req_wdata = req_wdata_d[0];
    assign bus_b.req_valid = req_valid_d[1];
    assign bus_b.req_write = req_write_d[1];
    assign bus_b.req_addr  = req_addr_d[1];
    assign bus_b.req_wdata = req_wdata_d[1];

    assign bus_a.mem_dout = bus_a.mem_ren ? sram_a[bus_a.mem_addr[11:0]] : 32'hx;
    assign bus_b.mem_dout = bus_b.mem_ren ? sram_b[bus_b.mem_addr[11:0]] : 32'hx;

    always @(posedge clock) begin
        if (bus_a.mem_wen) sram_a[bus_a.mem_addr[11:0]] <= bus_a.mem_din;
        if (bus_b.mem_wen) sram_b[bus_b.mem_addr[11:0]] <= bus_b.mem_din;
    end

    assign act[0] = {bus_a.req_ready, bus_a.busy, bus_a.resp_valid, bus_a.resp_error,
                     bus_a.resp_rdata, bus_a.mem_ren, bus_a.mem_wen, bus_a.mem_addr, bus_a.mem_din};
    assign act[1] = {bus_b.req_ready, bus_b.busy, bus_b.resp_valid, bus_b.resp_error,
                     bus_b.resp_rdata, bus_b.mem_ren, bus_b.mem_wen, bus_b.mem_addr, bus_b.mem_din};

    task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_respond(input int sel);
        m[sel].rerr  = m[sel].err;
        m[sel].rdata = (m[sel].err || m[sel].write) ? 32'd0 : mmem[sel][m[sel].idx[11:0]];
        if (!m[sel].err && m[sel].write) mmem[sel][m[sel].idx[11:0]] = m[sel].wdata;
    endtask

    task automatic model_step(input int sel);
        if (m[sel].active) begin
            if (m[sel].k == m[sel].lat) begin
                m[sel].active = 1'b0;
            end else begin
                m[sel].k++;
                if (m[sel].k == m[sel].lat) model_respond(sel);
            end
        end else if (req_valid_d[sel]) begin
            m[sel].active = 1'b1;
            m[sel].k      = 1;
            m[sel].write  = req_write_d[sel];
            m[sel].idx    = req_addr_d[sel] >> 2;
            m[sel].wdata  = req_wdata_d[sel];
            m[sel].err    = (req_addr_d[sel][1:0] != 2'b00) || ((m[sel].idx >> 12) != 0);
            m[sel].lat    = m[sel].err ? 1 : s_cyc[sel] + t_cyc[sel] + h_cyc[sel] + 1;
            if (m[sel].k == m[sel].lat) model_respond(sel);
        end
    endtask

    function automatic outs_t expect_outs(input model_t mm, input int s, input int t);
        outs_t e;
        e            = '0;
        e.req_ready  = 1'b1;
        e.resp_rdata = mm.rdata;
        e.resp_error = mm.rerr;
        if (mm.active) begin
            e.req_ready  = 1'b0;
            e.busy       = 1'b1;
            e.resp_valid = (mm.k == mm.lat);
            if (!mm.err) begin
                e.mem_ren  = !mm.write && mm.k > s && mm.k <= s + t;
                e.mem_wen  =  mm.write && mm.k > s && mm.k <= s + t;
                e.mem_addr = mm.idx;
                e.mem_din  = mm.write ? mm.wdata : 32'd0;
            end
        end
        return e;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                m[i].active = 1'b0;
                m[i].rdata  = '0;
                m[i].rerr   = 1'b0;
            end
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            check(i == 0 ? "cycle_a" : "cycle_b", 128'(act[i]),
                  128'(expect_outs(m[i], s_cyc[i], t_cyc[i])));
            check(i == 0 ? "ren_wen_a" : "ren_wen_b", 128'(act[i].mem_ren & act[i].mem_wen), 128'(0));
        end
        if (act[0].resp_valid) resp_q_a.push_back(act[0].resp_rdata);
    end

    // Address and write data must not move while the write strobe is high.
    logic [63:0] held_a;
    always @(negedge clock) begin
        if (!bus_a.mem_wen) held_a = {bus_a.mem_addr, bus_a.mem_din};
        else check("wen_stable", 128'({bus_a.mem_addr, bus_a.mem_din}), 128'(held_a));
    end

    task automatic set_req(input int sel, input bit v, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata);
        req_valid_d[sel] = v;
        req_write_d[sel] = wr;
        req_addr_d[sel]  = addr;
        req_wdata_d[sel] = wdata;
    endtask

    task automatic wait_ready(input int sel);
        bit got;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clock);
            got = act[sel].req_ready;
        end
        check("ready_timeout", 128'(got), 128'(1));
    endtask

    // Issues one request; masks record in which cycles (1 = after accept) signals were seen.
    task automatic run_req(input int sel, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           output int lat, output logic [31:0] rdata, output logic err,
                           output logic [31:0] ren_m, output logic [31:0] wen_m,
                           output logic [31:0] din_m, output logic [31:0] strobe_addr);
        bit got;
        lat = 0; rdata = '0; err = 1'b0; ren_m = '0; wen_m = '0; din_m = '0; strobe_addr = '0;
        @(posedge clock); #1;
        set_req(sel, 1'b1, wr, addr, wdata);
        wait_ready(sel);
        @(posedge clock); #1;
        req_valid_d[sel] = 1'b0;
        got = 1'b0;
        for (int c = 1; c <= 30 && !got; c++) begin
            @(negedge clock);
            if (act[sel].mem_ren) ren_m[c] = 1'b1;
            if (act[sel].mem_wen) wen_m[c] = 1'b1;
            if (act[sel].mem_ren || act[sel].mem_wen) strobe_addr = act[sel].mem_addr;
            if (act[sel].mem_din == wdata) din_m[c] = 1'b1;
            if (act[sel].resp_valid) begin
                got = 1'b1; lat = c; rdata = act[sel].resp_rdata; err = act[sel].resp_error;
            end
        end
        check("resp_timeout", 128'(got), 128'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] rd, renm, wenm, dinm, saddr;
        logic        er;
        outs_t       rst_exp;
        time         acc [3];
        time         t0;
        bit          rv;

        sram_a[5] = 32'hDEADBEEF; sram_b[5] = 32'hDEADBEEF;
        mmem[0][5] = 32'hDEADBEEF; mmem[1][5] = 32'hDEADBEEF;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);

        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        rst_exp = '0;
        rst_exp.req_ready = 1'b1;
        check("reset_state", 128'(act[0]), 128'(rst_exp));
        #2 reset = 1'b1;

        // Load from word 5
        run_req(0, 1'b0, 32'h14, 32'h0, lat, rd, er, renm, wenm, dinm, saddr);
        check("load_lat", 128'(lat), 128'(4));
        check("load_rdata", 128'(rd), 128'(32'hDEADBEEF));
        check("load_err", 128'(er), 128'(0));
        check("load_ren_cycles", 128'(renm), 128'(32'h4));
        check("load_wen_cycles", 128'(wenm), 128'(0));
        check("load_addr", 128'(saddr), 128'(5));

        // Store then read back
        run_req(0, 1'b1, 32'h20, 32'hCAFEF00D, lat, rd, er, renm, wenm, dinm, saddr);
        check("store_lat", 128'(lat), 128'(4));
        check("store_wen_cycles", 128'(wenm), 128'(32'h4));
        check("store_ren_cycles", 128'(renm), 128'(0));
        check("store_addr", 128'(saddr), 128'(8));
        check("store_din_cycles", 128'(dinm), 128'(32'h1E));
        check("store_rdata", 128'(rd), 128'(0));
        run_req(0, 1'b0, 32'h20, 32'h0, lat, rd, er, renm, wenm, dinm, saddr);
        check("readback_rdata", 128'(rd), 128'(32'hCAFEF00D));

        // Misaligned and out-of-range requests
        run_req(0, 1'b0, 32'h22, 32'h0, lat, rd, er, renm, wenm, dinm, saddr);
        check("misalign_lat", 128'(lat), 128'(1));
        check("misalign_err", 128'(er), 128'(1));
        check("misalign_rdata", 128'(rd), 128'(0));
        check("misalign_strobes", 128'(renm | wenm), 128'(0));
        run_req(0, 1'b1, 32'h4000, 32'h12345678, lat, rd, er, renm, wenm, dinm, saddr);
        check("range_lat", 128'(lat), 128'(1));
        check("range_err", 128'(er), 128'(1));
        check("range_rdata", 128'(rd), 128'(0));
        check("range_strobes", 128'(renm | wenm), 128'(0));

        // Back-to-back: req_valid held across three requests
        @(posedge clock); #1;
        resp_q_a.delete();
        set_req(0, 1'b1, 1'b1, 32'h30, 32'h11111111);
        for (int r = 0; r < 3; r++) begin
            wait_ready(0);
            @(posedge clock);
            acc[r] = $time;
            #1;
            if (r == 0) set_req(0, 1'b1, 1'b0, 32'h30, 32'h0);
            else if (r == 1) set_req(0, 1'b1, 1'b0, 32'h14, 32'h0);
            else req_valid_d[0] = 1'b0;
        end
        check("b2b_gap1", 128'(acc[1] - acc[0]), 128'(50));
        check("b2b_gap2", 128'(acc[2] - acc[1]), 128'(50));
        for (int n = 0; n < 40 && resp_q_a.size() < 3; n++) @(posedge clock);
        check("b2b_count", 128'(resp_q_a.size()), 128'(3));
        if (resp_q_a.size() == 3) begin
            check("b2b_resp0", 128'(resp_q_a[0]), 128'(0));
            check("b2b_resp1", 128'(resp_q_a[1]), 128'(32'h11111111));
            check("b2b_resp2", 128'(resp_q_a[2]), 128'(32'hDEADBEEF));
        end

        // Reset while a store is strobing
        @(posedge clock); #1;
        set_req(0, 1'b1, 1'b1, 32'h40, 32'h55AA55AA);
        wait_ready(0);
        @(posedge clock); #1;
        req_valid_d[0] = 1'b0;
        rv = 1'b0;
        for (int n = 0; n < 10 && !rv; n++) begin
            @(negedge clock);
            rv = act[0].mem_wen;
        end
        check("rst_wen_before", 128'(rv), 128'(1));
        #2;
        t0 = $time;
        reset = 1'b0;
        #1;
        check("rst_wen_async", 128'(bus_a.mem_wen), 128'(0));
        check("rst_time", 128'($time - t0), 128'(1));
        rv = 1'b0;
        repeat (2) begin
            @(negedge clock);
            if (act[0].resp_valid) rv = 1'b1;
        end
        #2 reset = 1'b1;
        repeat (6) begin
            @(negedge clock);
            if (act[0].resp_valid) rv = 1'b1;
        end
        check("rst_no_resp", 128'(rv), 128'(0));
        check("rst_ready", 128'(act[0].req_ready), 128'(1));
        run_req(0, 1'b0, 32'h14, 32'h0, lat, rd, er, renm, wenm, dinm, saddr);
        check("post_rst_lat", 128'(lat), 128'(4));
        check("post_rst_rdata", 128'(rd), 128'(32'hDEADBEEF));

        // Stretched timing 2/3/2
        run_req(1, 1'b0, 32'h14, 32'h0, lat, rd, er, renm, wenm, dinm, saddr);
        check("slow_lat", 128'(lat), 128'(8));
        check("slow_ren_cycles", 128'(renm), 128'(32'h38));
        check("slow_rdata", 128'(rd), 128'(32'hDEADBEEF));
        check("slow_addr", 128'(saddr), 128'(5));

        repeat (2) @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
